gtfmac_vnc_lat_mon_drain: RTL and testbench

Hardware drain sequencer for the latency monitor's send/receive timestamp FIFO. On a start command it pops timestamp pairs one at a time and computes a per-packet delta (receive − send − adjust). It accumulates sum, count, min and max, and flags completion, so software reads summary statistics instead of popping every entry over AXI-Lite. Sits between the latency monitor RAM/FIFO and the register interface, sharing the `lm_*` handshake.

---
 rtl/gtfmac_vnc_lat_mon_pkg.sv | 23 ++
 rtl/gtfmac_vnc_lat_delta_calc.sv | 38 +++
 rtl/gtfmac_vnc_lat_mon_drain.sv | 159 +++++++++++++++
 tb/tb_gtfmac_vnc_lat_mon_drain.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gtfmac_vnc_lat_mon_pkg.sv
// Shared definitions for the latency-monitor drain sequencer.
// Contents:
//   lat_drain_state_t  - drain FSM state encoding
//   ACCU_MAX           - saturation ceiling of the 32-bit delta accumulator
//   DEF_TIMER_WIDTH    - default timestamp / delta width
//   DEF_RAM_ADDR_WIDTH - default timestamp FIFO address width
package gtfmac_vnc_lat_mon_pkg;

   localparam int          DEF_TIMER_WIDTH    = 16;
   localparam int          DEF_RAM_ADDR_WIDTH = 12;
   localparam logic [31:0] ACCU_MAX           = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_POP,
      S_WAIT,
      S_CALC,
      S_UPDATE,
      S_DONE
   } lat_drain_state_t;

endpackage

// File: rtl/gtfmac_vnc_lat_delta_calc.sv
// Per-packet delta calculator for the latency drain sequencer.
// Computes (rcv_time - snd_time) modulo 2^TIMER_WIDTH so a timer wrap between
// send and receive still yields the true elapsed time, then removes the fixed
// path latency and clamps at zero. The result is registered when en is high.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   en              - load the result register this cycle
//   snd_time        - send timestamp
//   rcv_time        - receive timestamp
//   adj_factor      - fixed path latency to subtract
//   delta           - registered adjusted delta
module gtfmac_vnc_lat_delta_calc
   import gtfmac_vnc_lat_mon_pkg::*;
#(
   parameter int TIMER_WIDTH = DEF_TIMER_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [TIMER_WIDTH-1:0] snd_time,
   input  logic [TIMER_WIDTH-1:0] rcv_time,
   input  logic [TIMER_WIDTH-1:0] adj_factor,
   output logic [TIMER_WIDTH-1:0] delta
);

   // Natural width truncation gives the modulo subtraction for free.
   logic [TIMER_WIDTH-1:0] raw;
   assign raw = rcv_time - snd_time;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         delta <= '0;
      end else if (en) begin
         delta <= (raw > adj_factor) ? (raw - adj_factor) : '0;
      end
   end

endmodule

// File: rtl/gtfmac_vnc_lat_mon_drain.sv
// Drain sequencer for the latency monitor timestamp FIFO.
// On start it pops send/receive timestamp pairs one at a time, computes an
// adjusted delta per pair and accumulates sum, count, min and max so software
// only reads the summary.
// Ports:
//   axi_aclk, axi_aresetn           - clock, asynchronous active-low reset
//   start, abort                    - one-cycle run control pulses
//   pkt_target                      - samples per run, 0 = drain until empty
//   adj_factor                      - fixed path latency removed per delta
//   lm_datav                        - FIFO occupancy
//   lm_pop                          - one-cycle pop request
//   lm_time_rdy                     - popped pair valid
//   lm_snd_time, lm_rcv_time        - popped timestamp pair
//   delta_time_accu/idx/max/min     - run statistics
//   delta_done, busy, rdy_timeout   - status
module gtfmac_vnc_lat_mon_drain
   import gtfmac_vnc_lat_mon_pkg::*;
#(
   parameter int TIMER_WIDTH    = DEF_TIMER_WIDTH,
   parameter int RAM_ADDR_WIDTH = DEF_RAM_ADDR_WIDTH,
   parameter int RDY_TIMEOUT    = 64
) (
   input  logic                    axi_aclk,
   input  logic                    axi_aresetn,
   input  logic                    start,
   input  logic                    abort,
   input  logic [31:0]             pkt_target,
   input  logic [TIMER_WIDTH-1:0]  adj_factor,
   input  logic [RAM_ADDR_WIDTH:0] lm_datav,
   output logic                    lm_pop,
   input  logic                    lm_time_rdy,
   input  logic [TIMER_WIDTH-1:0]  lm_snd_time,
   input  logic [TIMER_WIDTH-1:0]  lm_rcv_time,
   output logic [31:0]             delta_time_accu,
   output logic [31:0]             delta_time_idx,
   output logic [TIMER_WIDTH-1:0]  delta_time_max,
   output logic [TIMER_WIDTH-1:0]  delta_time_min,
   output logic                    delta_done,
   output logic                    busy,
   output logic                    rdy_timeout
);

   localparam int CNT_W = $clog2(RDY_TIMEOUT + 1);

   lat_drain_state_t       state;
   logic [31:0]            target;
   logic [TIMER_WIDTH-1:0] adj;
   logic [TIMER_WIDTH-1:0] snd_q;
   logic [TIMER_WIDTH-1:0] rcv_q;
   logic [TIMER_WIDTH-1:0] delta;
   logic [CNT_W-1:0]       rdy_cnt;
   logic [32:0]            accu_sum;

   // One extra bit exposes the carry used for saturation.
   assign accu_sum = {1'b0, delta_time_accu} + 33'(delta);

   gtfmac_vnc_lat_delta_calc #(
      .TIMER_WIDTH (TIMER_WIDTH)
   ) u_delta_calc (
      .clk        (axi_aclk),
      .rst_n      (axi_aresetn),
      .en         (state == S_CALC),
      .snd_time   (snd_q),
      .rcv_time   (rcv_q),
      .adj_factor (adj),
      .delta      (delta)
   );

   // Abort pre-empts every non-idle state and leaves statistics and
   // delta_done untouched. In IDLE the start branch also rejects a
   // simultaneous abort. Statistics are written only on start and UPDATE.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state           <= S_IDLE;
         lm_pop          <= 1'b0;
         busy            <= 1'b0;
         delta_done      <= 1'b0;
         rdy_timeout     <= 1'b0;
         delta_time_accu <= '0;
         delta_time_idx  <= '0;
         delta_time_max  <= '0;
         delta_time_min  <= '1;
         target          <= '0;
         adj             <= '0;
         snd_q           <= '0;
         rcv_q           <= '0;
         rdy_cnt         <= '0;
      end else if (abort && (state != S_IDLE)) begin
         state  <= S_IDLE;
         lm_pop <= 1'b0;
         busy   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && !abort) begin
                  delta_time_accu <= '0;
                  delta_time_idx  <= '0;
                  delta_time_max  <= '0;
                  delta_time_min  <= '1;
                  delta_done      <= 1'b0;
                  rdy_timeout     <= 1'b0;
                  target          <= pkt_target;
                  adj             <= adj_factor;
                  busy            <= 1'b1;
                  state           <= S_CHECK;
               end
            end
            S_CHECK: begin
               if ((target != '0) && (delta_time_idx == target)) begin
                  delta_done <= 1'b1;
                  state      <= S_DONE;
               end else if (lm_datav != '0) begin
                  lm_pop <= 1'b1;
                  state  <= S_POP;
               end else if (target == '0) begin
                  delta_done <= 1'b1;
                  state      <= S_DONE;
               end
            end
            S_POP: begin
               lm_pop  <= 1'b0;
               rdy_cnt <= '0;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               if (lm_time_rdy) begin
                  snd_q <= lm_snd_time;
                  rcv_q <= lm_rcv_time;
                  state <= S_CALC;
               end else if (rdy_cnt == CNT_W'(RDY_TIMEOUT - 1)) begin
                  rdy_timeout <= 1'b1;
                  delta_done  <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  rdy_cnt <= rdy_cnt + 1'b1;
               end
            end
            S_CALC: begin
               state <= S_UPDATE;
            end
            S_UPDATE: begin
               delta_time_accu <= accu_sum[32] ? ACCU_MAX : accu_sum[31:0];
               delta_time_idx  <= delta_time_idx + 32'd1;
               if (delta > delta_time_max) delta_time_max <= delta;
               if (delta < delta_time_min) delta_time_min <= delta;
               state <= S_CHECK;
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gtfmac_vnc_lat_mon_drain.sv
// Self-checking bench for the latency drain sequencer. A queue models the
// timestamp FIFO, a responder process answers pops, and expected statistics
// are computed from the pairs actually delivered to the design.
module tb_gtfmac_vnc_lat_mon_drain;
   import gtfmac_vnc_lat_mon_pkg::*;

   localparam int TW = 16;
   localparam int AW = 12;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [31:0]   pkt_target = '0;
   logic [TW-1:0] adj_factor = '0;
   logic [AW:0]   lm_datav = '0;
   logic          lm_pop;
   logic          lm_time_rdy = 1'b0;
   logic [TW-1:0] lm_snd_time = '0;
   logic [TW-1:0] lm_rcv_time = '0;
   logic [31:0]   delta_time_accu;
   logic [31:0]   delta_time_idx;
   logic [TW-1:0] delta_time_max;
   logic [TW-1:0] delta_time_min;
   logic          delta_done;
   logic          busy;
   logic          rdy_timeout;

   int test_count = 0;
   int fail_count = 0;
   int pop_count = 0;
   int rdy_delay = 0;
   bit hold_rdy = 1'b0;

   logic [31:0] fifo_q[$];
   logic [31:0] consumed_q[$];

   gtfmac_vnc_lat_mon_drain #(
      .TIMER_WIDTH    (TW),
      .RAM_ADDR_WIDTH (AW),
      .RDY_TIMEOUT    (TO)
   ) dut (
      .axi_aclk        (clk),
      .axi_aresetn     (rst_n),
      .start           (start),
      .abort           (abort),
      .pkt_target      (pkt_target),
      .adj_factor      (adj_factor),
      .lm_datav        (lm_datav),
      .lm_pop          (lm_pop),
      .lm_time_rdy     (lm_time_rdy),
      .lm_snd_time     (lm_snd_time),
      .lm_rcv_time     (lm_rcv_time),
      .delta_time_accu (delta_time_accu),
      .delta_time_idx  (delta_time_idx),
      .delta_time_max  (delta_time_max),
      .delta_time_min  (delta_time_min),
      .delta_done      (delta_done),
      .busy            (busy),
      .rdy_timeout     (rdy_timeout)
   );

   always #5 clk = ~clk;

   // FIFO responder: on a pop the head entry leaves the queue and, unless
   // held back, is presented with lm_time_rdy for one cycle after a delay.
   initial begin
      logic [31:0] ent;
      int lat;
      forever begin
         @(negedge clk);
         if (lm_pop === 1'b1) begin
            pop_count++;
            ent = (fifo_q.size() > 0) ? fifo_q.pop_front() : 32'h0;
            lm_datav = (AW+1)'(fifo_q.size());
            if (!hold_rdy) begin
               lat = (rdy_delay != 0) ? rdy_delay : int'($urandom_range(1, 4));
               repeat (lat) @(negedge clk);
               lm_snd_time = ent[31:16];
               lm_rcv_time = ent[15:0];
               lm_time_rdy = 1'b1;
               consumed_q.push_back(ent);
               @(negedge clk);
               lm_time_rdy = 1'b0;
            end
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      test_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic pushEntry(input logic [TW-1:0] snd, input logic [TW-1:0] rcv);
      fifo_q.push_back({snd, rcv});
      lm_datav = (AW+1)'(fifo_q.size());
   endtask

   task automatic flushFifo();
      fifo_q.delete();
      lm_datav = '0;
   endtask

   // Pulses start at a falling edge; returns one cycle later.
   task automatic applyStimulus(input logic [31:0] target, input logic [TW-1:0] adj, input logic with_abort);
      @(negedge clk);
      consumed_q.delete();
      pop_count = 0;
      pkt_target = target;
      adj_factor = adj;
      start = 1'b1;
      abort = with_abort;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int budget);
      int n;
      n = 0;
      while (delta_done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_done"}, 64'(delta_done), 64'd1);
   endtask

   task automatic waitPops(input int count, input int budget);
      int n;
      n = 0;
      while (pop_count < count && n < budget) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Reference statistics derived from the delivered pairs.
   task automatic checkStats(input string tag, input logic [TW-1:0] adj, input longint base, input int exp_pops);
      longint accu;
      int idx, mx, mn, raw, d;
      accu = base;
      idx = 0;
      mx = 0;
      mn = (1 << TW) - 1;
      foreach (consumed_q[i]) begin
         raw = ((int'(consumed_q[i][15:0]) - int'(consumed_q[i][31:16])) % (1 << TW) + (1 << TW)) % (1 << TW);
         d = (raw > int'(adj)) ? raw - int'(adj) : 0;
         accu = accu + d;
         if (accu > 64'hFFFF_FFFF) accu = 64'hFFFF_FFFF;
         idx++;
         if (d > mx) mx = d;
         if (d < mn) mn = d;
      end
      checkOutput({tag, "_accu"}, 64'(delta_time_accu), 64'(accu));
      checkOutput({tag, "_idx"}, 64'(delta_time_idx), 64'(idx));
      checkOutput({tag, "_max"}, 64'(delta_time_max), 64'(mx));
      checkOutput({tag, "_min"}, 64'(delta_time_min), 64'(mn));
      checkOutput({tag, "_pops"}, 64'(pop_count), 64'(exp_pops));
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_pop"}, 64'(lm_pop), 64'd0);
      checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
      checkOutput({tag, "_done"}, 64'(delta_done), 64'd0);
      checkOutput({tag, "_to"}, 64'(rdy_timeout), 64'd0);
      checkOutput({tag, "_accu"}, 64'(delta_time_accu), 64'd0);
      checkOutput({tag, "_idx"}, 64'(delta_time_idx), 64'd0);
      checkOutput({tag, "_max"}, 64'(delta_time_max), 64'd0);
      checkOutput({tag, "_min"}, 64'(delta_time_min), 64'hFFFF);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n, r, tgt, samples;
      logic [TW-1:0] adj;

      repeat (3) @(negedge clk);
      checkReset("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed four-pair run with start-to-pop latency check.
      pushEntry(16'd10, 16'd110);
      pushEntry(16'd20, 16'd150);
      pushEntry(16'd30, 16'd80);
      pushEntry(16'd40, 16'd240);
      applyStimulus(32'd4, '0, 1'b0);
      checkOutput("lat_pop_early", 64'(lm_pop), 64'd0);
      checkOutput("lat_busy", 64'(busy), 64'd1);
      @(negedge clk);
      checkOutput("lat_pop", 64'(lm_pop), 64'd1);
      waitDone("four", 200);
      checkStats("four", '0, 0, 4);
      checkOutput("four_max_c", 64'(delta_time_max), 64'd200);
      checkOutput("four_min_c", 64'(delta_time_min), 64'd50);
      @(negedge clk);
      checkOutput("four_done_held", 64'(delta_done), 64'd1);
      checkOutput("four_idle_busy", 64'(busy), 64'd0);

      // Timer wrap.
      pushEntry(16'hFFF0, 16'h0010);
      applyStimulus(32'd1, 16'd5, 1'b0);
      waitDone("wrap", 100);
      checkOutput("wrap_accu_c", 64'(delta_time_accu), 64'd27);
      checkStats("wrap", 16'd5, 0, 1);

      // Clamp at zero.
      pushEntry(16'd100, 16'd103);
      pushEntry(16'd0, 16'd50);
      applyStimulus(32'd2, 16'd10, 1'b0);
      waitDone("clamp", 100);
      checkOutput("clamp_min_c", 64'(delta_time_min), 64'd0);
      checkStats("clamp", 16'd10, 0, 2);

      // Drain-until-empty.
      for (int i = 0; i < 3; i++) pushEntry(TW'($urandom), TW'($urandom));
      applyStimulus(32'd0, 16'd3, 1'b0);
      waitDone("empty", 200);
      checkStats("empty", 16'd3, 0, 3);

      // Target larger than available data: waits in CHECK until refilled.
      for (int i = 0; i < 3; i++) pushEntry(TW'($urandom), TW'($urandom));
      applyStimulus(32'd5, 16'd0, 1'b0);
      waitPops(3, 200);
      repeat (10) @(negedge clk);
      checkOutput("starve_busy", 64'(busy), 64'd1);
      checkOutput("starve_done", 64'(delta_done), 64'd0);
      checkOutput("starve_idx", 64'(delta_time_idx), 64'd3);
      pushEntry(TW'($urandom), TW'($urandom));
      pushEntry(TW'($urandom), TW'($urandom));
      waitDone("starve", 200);
      checkStats("starve", 16'd0, 0, 5);

      // Randomised runs.
      for (int run = 0; run < 8; run++) begin
         n = int'($urandom_range(1, 6));
         for (int i = 0; i < n; i++) pushEntry(TW'($urandom), TW'($urandom));
         r = int'($urandom_range(0, 2));
         tgt = (r == 0) ? 0 : (r == 1) ? n : int'($urandom_range(1, n));
         samples = (tgt == 0) ? n : tgt;
         adj = TW'($urandom_range(0, 300));
         applyStimulus(32'(tgt), adj, 1'b0);
         waitDone("rand", 400);
         checkStats("rand", adj, 0, samples);
         flushFifo();
      end

      // Saturation: preload the accumulator while waiting in CHECK.
      applyStimulus(32'd1, 16'd0, 1'b0);
      repeat (5) @(negedge clk);
      force dut.delta_time_accu = 32'hFFFF_FFF0;
      #1;
      release dut.delta_time_accu;
      @(negedge clk);
      pushEntry(16'd0, 16'd100);
      waitDone("sat", 100);
      checkOutput("sat_accu_c", 64'(delta_time_accu), 64'hFFFF_FFFF);
      checkStats("sat", 16'd0, 64'hFFFF_FFF0, 1);

      // Ready timeout.
      hold_rdy = 1'b1;
      pushEntry(16'd1, 16'd2);
      applyStimulus(32'd1, 16'd0, 1'b0);
      waitPops(1, 50);
      repeat (50) @(negedge clk);
      checkOutput("to_busy_early", 64'(busy), 64'd1);
      checkOutput("to_done_early", 64'(delta_done), 64'd0);
      waitDone("to", 40);
      checkOutput("to_flag", 64'(rdy_timeout), 64'd1);
      checkOutput("to_idx", 64'(delta_time_idx), 64'd0);
      hold_rdy = 1'b0;
      flushFifo();

      // Abort during WAIT; the late ready must be ignored.
      rdy_delay = 10;
      pushEntry(16'd5, 16'd500);
      applyStimulus(32'd1, 16'd0, 1'b0);
      checkOutput("abort_to_clear", 64'(rdy_timeout), 64'd0);
      waitPops(1, 50);
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      repeat (15) @(negedge clk);
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_done", 64'(delta_done), 64'd0);
      checkOutput("abort_idx", 64'(delta_time_idx), 64'd0);
      checkOutput("abort_accu", 64'(delta_time_accu), 64'd0);
      checkOutput("abort_min", 64'(delta_time_min), 64'hFFFF);
      rdy_delay = 0;
      flushFifo();

      // Abort beats a simultaneous start in IDLE.
      pushEntry(16'd1, 16'd9);
      applyStimulus(32'd1, 16'd0, 1'b1);
      repeat (5) @(negedge clk);
      checkOutput("abst_busy", 64'(busy), 64'd0);
      checkOutput("abst_pops", 64'(pop_count), 64'd0);

      // Reset in UPDATE.
      pushEntry(16'd1, 16'd60);
      applyStimulus(32'd2, 16'd0, 1'b0);
      n = 0;
      while (dut.state != S_UPDATE && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("rst_reach_update", 64'(n < 100), 64'd1);
      rst_n = 1'b0;
      #1;
      checkReset("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      flushFifo();
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
